score_keeper: RTL and testbench

- Game-state and scoring stage that sits directly downstream of game_controller.
- Consumes the per-pixel collision level and frame timing, and turns them into a saturating 3-digit BCD score, a lives count, a respawn delay and a game-over state.
- Also tracks a session high score.
- Its outputs drive the hex_ss displays, LEDR, and smiley_block's motion enable.

---
 rtl/score_keeper.sv | 93 +++++++++
 tb/tb_score_keeper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: once-per-frame hit scoring in saturating BCD, lives, respawn delay, game over and session high score.
module score_keeper #(
  parameter int POINTS_PER_HIT = 1,
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        collision,
  input  logic        ball_lost,
  input  logic        new_game,
  output logic [11:0] score_bcd,
  output logic [11:0] high_score_bcd,
  output logic [1:0]  lives,
  output logic        ball_enable,
  output logic        game_over,
  output logic        score_pulse
);
  typedef enum logic [1:0] {PLAY, RESPAWN, GAME_OVER} state_t;
  state_t      state_q, state_d;
  logic [11:0] score_q, score_d, high_q, high_d, sum;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  frame_q, frame_d;
  logic        hit_cur_q, hit_cur_d, hit_prev_q, hit_prev_d, pulse_q, pulse_d;
  logic        counted, score_en, sat;
  logic [4:0]  u, t, h;
  always_comb begin
    u = {1'b0, score_q[3:0]} + 5'(POINTS_PER_HIT);
    t = {1'b0, score_q[7:4]} + {4'd0, u > 5'd9};
    h = {1'b0, score_q[11:8]} + {4'd0, t > 5'd9};
    sat = h > 5'd9;
    sum = sat ? 12'h999 : {h[3:0], t > 5'd9 ? 4'(t - 5'd10) : t[3:0], u > 5'd9 ? 4'(u - 5'd10) : u[3:0]};
  end
  assign counted  = startOfFrame & hit_cur_q & ~hit_prev_q;
  assign score_en = counted && state_q == PLAY && score_q != 12'h999;
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    frame_d    = frame_q;
    pulse_d    = 1'b0;
    hit_cur_d  = startOfFrame ? collision : hit_cur_q | collision;
    hit_prev_d = startOfFrame ? hit_cur_q : hit_prev_q;
    high_d     = (state_q == GAME_OVER && score_q > high_q) ? score_q : high_q;
    if (new_game) begin
      state_d    = PLAY;
      score_d    = 12'h000;
      lives_d    = 2'(LIVES_INIT);
      frame_d    = 8'd0;
      hit_cur_d  = 1'b0;
      hit_prev_d = 1'b0;
    end else if (state_q == PLAY && ball_lost) begin
      lives_d = lives_q - 2'd1;
      state_d = lives_q == 2'd1 ? GAME_OVER : RESPAWN;
      frame_d = 8'd0;
    end else begin
      score_d = score_en ? sum : score_q;
      pulse_d = score_en;
      if (state_q == RESPAWN && startOfFrame) begin
        frame_d = frame_q + 8'd1;
        state_d = frame_d == 8'(RESPAWN_FRAMES) ? PLAY : RESPAWN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PLAY;
      score_q    <= 12'h000;
      high_q     <= 12'h000;
      lives_q    <= 2'(LIVES_INIT);
      frame_q    <= 8'd0;
      hit_cur_q  <= 1'b0;
      hit_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      lives_q    <= lives_d;
      frame_q    <= frame_d;
      hit_cur_q  <= hit_cur_d;
      hit_prev_q <= hit_prev_d;
      pulse_q    <= pulse_d;
    end
  end
  assign score_bcd      = score_q;
  assign high_score_bcd = high_q;
  assign lives          = lives_q;
  assign ball_enable    = state_q == PLAY;
  assign game_over      = state_q == GAME_OVER;
  assign score_pulse    = pulse_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: vector table, corner sequences and random stimulus against an integer game model.
module tb_score_keeper;
  localparam int P = 1, LI = 3, RF = 60;
  logic        clk = 1'b0, reset = 1'b1, sof = 1'b0, col = 1'b0, bl = 1'b0, ng = 1'b0;
  logic [11:0] score_bcd, high_score_bcd;
  logic [1:0]  lives;
  logic        ball_enable, game_over, score_pulse;
  int          checks = 0, failures = 0;
  int          m_score, m_high, m_lives, m_state, m_frames;
  bit          m_cur, m_prev, m_pulse;

  score_keeper #(.POINTS_PER_HIT(P), .LIVES_INIT(LI), .RESPAWN_FRAMES(RF)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .collision(col), .ball_lost(bl), .new_game(ng),
    .score_bcd(score_bcd), .high_score_bcd(high_score_bcd), .lives(lives),
    .ball_enable(ball_enable), .game_over(game_over), .score_pulse(score_pulse));

  always #5 clk = ~clk;

  function automatic logic [11:0] bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic model_reset;
    m_score = 0; m_high = 0; m_lives = LI; m_state = 0; m_frames = 0;
    m_cur = 0; m_prev = 0; m_pulse = 0;
  endtask

  // states: 0 play, 1 respawn, 2 game over; score held as a plain integer
  task automatic model_step;
    bit counted;
    int s, h, l, st, f;
    s = m_score; h = m_high; l = m_lives; st = m_state; f = m_frames;
    counted = sof && m_cur && !m_prev;
    m_pulse = 0;
    if (m_state == 2 && m_score > m_high) h = m_score;
    if (ng) begin
      s = 0; l = LI; st = 0; f = 0;
    end else if (m_state == 0 && bl) begin
      l = m_lives - 1; st = (l == 0) ? 2 : 1; f = 0;
    end else begin
      if (counted && m_state == 0 && m_score < 999) begin
        s = (m_score + P > 999) ? 999 : m_score + P;
        m_pulse = 1;
      end
      if (m_state == 1 && sof) begin
        f = m_frames + 1;
        if (f == RF) st = 0;
      end
    end
    if (ng) begin
      m_cur = 0; m_prev = 0;
    end else if (sof) begin
      m_prev = m_cur; m_cur = col;
    end else m_cur = m_cur | col;
    m_score = s; m_high = h; m_lives = l; m_state = st; m_frames = f;
  endtask

  task automatic step(bit s_, bit c_, bit b_, bit n_);
    sof = s_; col = c_; bl = b_; ng = n_;
    if (reset) model_reset(); else model_step();
    @(posedge clk);
    #1;
    chk("cycle", {3'd0, score_bcd, high_score_bcd, lives, ball_enable, game_over, score_pulse},
        {3'd0, bcd(m_score), bcd(m_high), 2'(m_lives), m_state == 0, m_state == 2, m_pulse});
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic hit;
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic frame(bit c);
    for (int i = 0; i < 9; i++) step(0, c, 0, 0);
    step(1, c, 0, 0);
  endtask

  task automatic respawn;
    for (int i = 0; i < RF; i++) begin
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
    end
  endtask

  typedef struct {
    bit s, c, b, n;
    logic [11:0] score;
    logic [1:0]  l;
    bit be, p;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{0, 1, 0, 0, 12'h000, 2'd3, 1, 0};
    tbl[1]  = '{0, 1, 0, 0, 12'h000, 2'd3, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 12'h001, 2'd3, 1, 1};
    tbl[3]  = '{0, 0, 0, 0, 12'h001, 2'd3, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 12'h001, 2'd3, 1, 0};
    tbl[5]  = '{0, 1, 0, 0, 12'h001, 2'd3, 1, 0};
    tbl[6]  = '{1, 1, 0, 0, 12'h002, 2'd3, 1, 1};
    tbl[7]  = '{1, 0, 0, 0, 12'h002, 2'd3, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 12'h002, 2'd3, 1, 0};
    tbl[9]  = '{0, 0, 1, 0, 12'h002, 2'd2, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 12'h000, 2'd3, 1, 0};
    tbl[11] = '{0, 0, 1, 1, 12'h000, 2'd3, 1, 0};
    tbl[12] = '{0, 0, 1, 0, 12'h000, 2'd2, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 12'h000, 2'd2, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 12'h000, 2'd2, 0, 0};

    do_reset();
    chk("reset_score", score_bcd, 12'h000);
    chk("reset_high", high_score_bcd, 12'h000);
    chk("reset_lives", lives, 2'd3);
    chk("reset_enable", ball_enable, 1'b1);
    chk("reset_go", game_over, 1'b0);
    chk("reset_pulse", score_pulse, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].c, tbl[i].b, tbl[i].n);
      chk($sformatf("vec%0d", i), {score_bcd, lives, ball_enable, score_pulse},
          {tbl[i].score, tbl[i].l, tbl[i].be, tbl[i].p});
    end

    do_reset();
    for (int i = 0; i < 4; i++) frame(1);
    chk("held_once", score_bcd, 12'h001);
    frame(0);
    frame(0);
    frame(1);
    chk("gap_rescore", score_bcd, 12'h002);

    do_reset();
    for (int i = 0; i < 99; i++) hit();
    chk("preload_99", score_bcd, 12'h099);
    hit();
    chk("carry_100", score_bcd, 12'h100);
    for (int i = 0; i < 898; i++) hit();
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("reach_999", {score_bcd, score_pulse}, {12'h999, 1'b1});
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("sat_999", {score_bcd, score_pulse}, {12'h999, 1'b0});

    do_reset();
    step(0, 0, 1, 0);
    chk("lost_lives", {lives, ball_enable}, {2'd2, 1'b0});
    for (int i = 0; i < RF - 1; i++) begin
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
    end
    chk("respawn_59", {score_bcd, ball_enable}, {12'h000, 1'b0});
    step(1, 0, 0, 0);
    chk("respawn_60", ball_enable, 1'b1);

    do_reset();
    for (int i = 0; i < 42; i++) hit();
    step(0, 0, 1, 0);
    respawn();
    step(0, 0, 1, 0);
    respawn();
    step(0, 0, 1, 0);
    chk("game_over", {game_over, ball_enable, lives}, {1'b1, 1'b0, 2'd0});
    step(0, 0, 0, 0);
    chk("high_42", high_score_bcd, 12'h042);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("frozen", score_bcd, 12'h042);
    step(0, 0, 0, 1);
    chk("new_game", {score_bcd, lives, ball_enable, game_over, high_score_bcd},
        {12'h000, 2'd3, 1'b1, 1'b0, 12'h042});

    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    reset = 1'b1;
    step(1, 1, 0, 0);
    reset = 1'b0;
    chk("reset_mid_respawn", {score_bcd, high_score_bcd, lives, ball_enable, game_over, score_pulse},
        {12'h000, 12'h000, 2'd3, 1'b1, 1'b0, 1'b0});
    step(0, 1, 0, 0);
    reset = 1'b1;
    step(1, 0, 0, 0);
    reset = 1'b0;
    chk("reset_mid_inc", {score_bcd, score_pulse}, {12'h000, 1'b0});

    for (int i = 0; i < 6000; i++) begin
      reset = $urandom_range(0, 999) == 0;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
